uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning uartTick pulses per serial bit (power of two, 4..64).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop-bit count per frame (1 or 2).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port uartTick  input  1  one-clock strobe from the baud rate generator at OVERSAMPLE x bit rate.
REQ-006 SHALL have ports req0 / req1  input  1 each  byte-send request, requester 0 / requester 1.
REQ-007 SHALL have ports data0 / data1  input  8 each  byte to send; held stable while req is high.
REQ-008 SHALL have ports ack0 / ack1  output  1 each  one-clock pulse; byte latched, requester may drop req.
REQ-009 SHALL have port TxD  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from grant through end of the last stop bit.
REQ-011 SHALL have port grantId  output  1  requester owning the current or most recent frame.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; only IDLE arbitrates.
REQ-013 In IDLE with exactly one req high at an edge, SHALL grant that requester at that edge: latch its data into an 8-bit shift register, set grantId, enter START.
REQ-014 In IDLE with both req high, SHALL grant the requester not granted last (round robin); after reset the last-grant record is 1, so requester 0 wins the first tie.
REQ-015 SHALL register ackN high for exactly the one clock after the grant edge; the other ack stays low.
REQ-016 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-017 req and data changes while not in IDLE SHALL be ignored; no ack occurs outside the grant.
REQ-018 SHALL hold a tick counter of log2(OVERSAMPLE) bits, cleared at the grant edge, incremented only on uartTick while not in IDLE, and wrapping to 0 on each bit boundary.
REQ-019 A bit boundary SHALL be the edge where uartTick is high and the tick counter equals OVERSAMPLE-1.
REQ-020 In START, TxD SHALL be 0; at the bit boundary SHALL enter DATA with bit index 0.
REQ-021 In DATA, TxD SHALL be shift-register bit 0 (LSB first); at each bit boundary SHALL shift right and increment a 3-bit bit index; at the boundary with index 7 SHALL enter STOP.
REQ-022 In STOP, TxD SHALL be 1 for STOP_BITS bit times; at the final boundary SHALL enter IDLE and drop busy.
REQ-023 TxD SHALL be driven from a register (glitch-free); TxD is 1 in IDLE.
REQ-024 A frame SHALL last (9+STOP_BITS) x OVERSAMPLE uartTick pulses after the grant; the start bit may extend by under one tick period, depending on tick phase.
REQ-025 Back-to-back frames SHALL have at least one IDLE clock between the STOP->IDLE edge and the next grant.
REQ-026 uartTick in IDLE SHALL be ignored; uartTick in the same cycle as a grant SHALL NOT count.
REQ-027 busy SHALL be high in START, DATA and STOP and low in IDLE.

Reset
REQ-028 Reset high SHALL immediately force state IDLE, TxD=1, busy=0, ack0=ack1=0, grantId=0, tick counter=0, bit index=0, shift register=0, and last-grant record=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further ack; the requester re-requests after Reset falls.
REQ-030 The first grant SHALL occur no earlier than the first rising clock edge after Reset deasserts.

Verification
REQ-031 Single send: OVERSAMPLE=16, req0=1, data0=8'hA5, tick every 4 clocks -> ack0 one cycle; TxD = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; busy low after 160 ticks.
REQ-032 Tie: req0=req1=1 from reset, data0=8'h11, data1=8'h22, both held after ack -> frames sent in order 8'h11, 8'h22, 8'h11; grantId 0,1,0; one IDLE cycle between frames.
REQ-033 Ignored changes: during the frame for data1=8'h3C, toggle req0 and change data1 -> serialized byte stays 8'h3C; no ack0 until IDLE.
REQ-034 Reset mid-frame: assert Reset during DATA bit 4 -> TxD=1 and busy=0 the same cycle; no ack; a later req1 gets a clean, full frame.
REQ-035 STOP_BITS=2, uartTick tied high -> frame spans 11x16=176 clocks plus the grant cycle; stop level high for 32 clocks.
REQ-036 Tick phase: uartTick high in the grant cycle -> that tick is not counted; the start bit still spans 16 counted ticks.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin grant in IDLE, then start, 8 data bits LSB first, and STOP_BITS stop bits.
// Latency: grant on the first edge that sees a request in IDLE; ack the next cycle; frame lasts (9+STOP_BITS)*OVERSAMPLE ticks.
// Backpressure: a requester holds req/data until its ack; requests are not sampled while a frame is in flight (busy high).
module uart_tx_scheduler #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       uartTick,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       TxD,
  output logic       busy,
  output logic       grantId
);

  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          last_grant;

  logic          grant;
  logic          pick;
  logic          bit_end;

  // Arbitration and bit-boundary decode; on a tie the requester not served last wins.
  always_comb begin
    grant   = 1'b0;
    pick    = 1'b0;
    bit_end = 1'b0;
    if (state == IDLE) begin
      grant = req0 | req1;
      pick  = (req0 & req1) ? ~last_grant : req1;
    end
    bit_end = (state != IDLE) && uartTick && (tick_cnt == TICK_LAST);
  end

  // Frame sequencer: owns state, shift register, bit index and the registered serial line.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      TxD        <= 1'b1;
      busy       <= 1'b0;
      grantId    <= 1'b0;
      last_grant <= 1'b1;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= START;
            shreg      <= pick ? data1 : data0;
            grantId    <= pick;
            last_grant <= pick;
            bit_idx    <= 3'd0;
            TxD        <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            TxD     <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= 3'd0;
              TxD     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Next bit to appear is the one about to shift into position 0.
              TxD     <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              state   <= IDLE;
              bit_idx <= 3'd0;
              busy    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Oversample counter: held at zero in IDLE so a tick coinciding with the grant is not counted.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
    end else if (uartTick) begin
      tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  // Ack pulses: high for exactly the cycle following the grant edge.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= grant & ~pick;
      ack1 <= grant & pick;
    end
  end

endmodule
